// File: rtl/stage_bias_ctrl_pkg.sv
// Shared types and sizing for the stage bias sequencer: bias word layout and FSM states.
package stage_bias_ctrl_pkg;

  localparam int unsigned BIAS_WIDTH = 32;
  localparam int unsigned BIAS_AW    = 3;
  localparam int unsigned BIAS_DEPTH = 2 ** BIAS_AW;

  typedef struct packed {
    logic [BIAS_WIDTH-1:0] data;
    logic [BIAS_AW-1:0]    idx;
    logic                  last;
  } bias_word_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/stage_bias_skid.sv
// 2-entry valid/ready FIFO; when empty the incoming word flows straight to the head.
module stage_bias_skid #(
  parameter int unsigned PW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_valid,
  input  logic [PW-1:0] i_data,
  output logic          o_valid,
  input  logic          i_ready,
  output logic [PW-1:0] o_data,
  output logic [1:0]    o_count
);

  logic [PW-1:0] r_mem [2];
  logic          r_rd;
  logic          r_wr;
  logic [1:0]    r_cnt;

  logic w_empty;
  logic w_pop;
  logic w_push;
  logic w_pop_mem;

  assign w_empty   = (r_cnt == 2'd0);
  assign o_valid   = !w_empty || i_valid;
  assign o_data    = !w_empty ? r_mem[r_rd] : (i_valid ? i_data : '0);
  assign o_count   = r_cnt;
  assign w_pop     = o_valid && i_ready;
  // A word consumed on the bypass path never enters storage.
  assign w_push    = i_valid && !(w_empty && i_ready);
  assign w_pop_mem = w_pop && !w_empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_rd     <= 1'b0;
      r_wr     <= 1'b0;
      r_cnt    <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= i_data;
        r_wr        <= ~r_wr;
      end
      if (w_pop_mem) begin
        r_rd <= ~r_rd;
      end
      r_cnt <= r_cnt + 2'(w_push) - 2'(w_pop_mem);
    end
  end

endmodule

// File: rtl/stage_bias_ctrl.sv
// Bias memory sequencer: loader writes while idle, then streams biases 0..len-1 on start.
// Optional stall counter output enabled by STAGE_BIAS_CTRL_STALL_CNT_EN.
module stage_bias_ctrl
  import stage_bias_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = BIAS_WIDTH,
  parameter int unsigned AW    = BIAS_AW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [AW:0]      cfg_len,
  input  logic             start,
  output logic             busy,
  output logic             done,
  input  logic             ld_valid,
  output logic             ld_ready,
  input  logic [AW-1:0]    ld_addr,
  input  logic [WIDTH-1:0] ld_data,
  output logic             mem_wr_en,
  output logic [AW-1:0]    mem_wr_addr,
  output logic [WIDTH-1:0] mem_wr_data,
  output logic             mem_rd_en,
  output logic [AW-1:0]    mem_rd_addr,
  input  logic [WIDTH-1:0] mem_rd_data,
  output logic             bias_valid,
  input  logic             bias_ready,
  output logic [WIDTH-1:0] bias_data,
  output logic [AW-1:0]    bias_idx,
  output logic             bias_last
`ifdef STAGE_BIAS_CTRL_STALL_CNT_EN
  ,
  output logic [15:0]      stall_cnt
`endif
);

  localparam int unsigned PW      = WIDTH + AW + 1;
  localparam logic [AW:0] DEPTH_L = (AW+1)'(2 ** AW);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [AW:0]   r_len;
  logic [AW:0]   r_rd_ptr;
  logic          r_pend;
  logic [AW-1:0] r_pend_idx;
  logic          r_pend_last;

  logic [AW:0]   w_len_clamp;
  logic          w_start_acc;
  logic          w_credit_ok;
  logic          w_issue;
  logic          w_issue_last;
  logic          w_last_acc;
  logic          w_wr;
  logic [1:0]    w_skid_cnt;
  logic          w_skid_valid;
  logic [PW-1:0] w_skid_in;
  logic [PW-1:0] w_skid_out;

  assign w_len_clamp  = (cfg_len > DEPTH_L) ? DEPTH_L : cfg_len;
  assign w_start_acc  = (r_state == ST_IDLE) && start;
  // Reads in flight plus buffered words never exceed the two skid slots.
  assign w_credit_ok  = (2'(r_pend) + w_skid_cnt) < 2'd2;
  assign w_issue_last = (r_rd_ptr == (r_len - (AW+1)'(1)));
  assign w_last_acc   = w_skid_valid && bias_ready && bias_last;

  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = (w_len_clamp == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        busy = 1'b1;
        if (w_credit_ok) begin
          w_issue = 1'b1;
          if (w_issue_last) begin
            w_state_nxt = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        busy = 1'b1;
        if (w_last_acc) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        done        = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_len       <= '0;
      r_rd_ptr    <= '0;
      r_pend      <= 1'b0;
      r_pend_idx  <= '0;
      r_pend_last <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start_acc) begin
        r_len    <= w_len_clamp;
        r_rd_ptr <= '0;
      end else if (w_issue) begin
        r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
      end
      r_pend      <= w_issue;
      r_pend_idx  <= r_rd_ptr[AW-1:0];
      r_pend_last <= w_issue_last;
    end
  end

  // Loader writes pass straight through; a simultaneous start takes priority.
  assign ld_ready    = (r_state == ST_IDLE) && !start;
  assign w_wr        = ld_valid && ld_ready;
  assign mem_wr_en   = w_wr;
  assign mem_wr_addr = w_wr ? ld_addr : '0;
  assign mem_wr_data = w_wr ? ld_data : '0;

  assign mem_rd_en   = w_issue;
  assign mem_rd_addr = w_issue ? r_rd_ptr[AW-1:0] : '0;

  assign w_skid_in = {mem_rd_data, r_pend_idx, r_pend_last};

  stage_bias_skid #(
    .PW (PW)
  ) u_skid (
    .clk     (clk),
    .reset   (reset),
    .i_valid (r_pend),
    .i_data  (w_skid_in),
    .o_valid (w_skid_valid),
    .i_ready (bias_ready),
    .o_data  (w_skid_out),
    .o_count (w_skid_cnt)
  );

  assign bias_valid = w_skid_valid;
  assign {bias_data, bias_idx, bias_last} = w_skid_out;

`ifdef STAGE_BIAS_CTRL_STALL_CNT_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= 16'd0;
    end else if (w_start_acc) begin
      r_stall_cnt <= 16'd0;
    end else if (w_skid_valid && !bias_ready && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_stage_bias_ctrl.sv
// Self-checking bench for stage_bias_ctrl: directed passes plus randomized loads/passes vs a queue model.
module tb_stage_bias_ctrl;
  import stage_bias_ctrl_pkg::*;

  localparam int unsigned W     = BIAS_WIDTH;
  localparam int unsigned AW    = BIAS_AW;
  localparam int unsigned DEPTH = BIAS_DEPTH;

  logic          clk;
  logic          reset;
  logic [AW:0]   cfg_len;
  logic          start;
  logic          busy;
  logic          done;
  logic          ld_valid;
  logic          ld_ready;
  logic [AW-1:0] ld_addr;
  logic [W-1:0]  ld_data;
  logic          mem_wr_en;
  logic [AW-1:0] mem_wr_addr;
  logic [W-1:0]  mem_wr_data;
  logic          mem_rd_en;
  logic [AW-1:0] mem_rd_addr;
  logic [W-1:0]  mem_rd_data;
  logic          bias_valid;
  logic          bias_ready;
  logic [W-1:0]  bias_data;
  logic [AW-1:0] bias_idx;
  logic          bias_last;
`ifdef STAGE_BIAS_CTRL_STALL_CNT_EN
  logic [15:0]   stall_cnt;
`endif

  int tests = 0;
  int fails = 0;

  logic [W-1:0] mem     [DEPTH];
  logic [W-1:0] ref_mem [DEPTH];
  bias_word_t   exp_q [$];
  bias_word_t   mon_e;

  bit           mon_en = 1'b0;
  int           n_issued = 0;
  int           n_accepted = 0;
  int           done_cnt = 0;
  bit           last_acc_prev = 1'b0;
  bit           prev_stall = 1'b0;
  logic [W-1:0] prev_data;
  logic [AW-1:0] prev_idx;
  logic         prev_last;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  stage_bias_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .cfg_len     (cfg_len),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .ld_valid    (ld_valid),
    .ld_ready    (ld_ready),
    .ld_addr     (ld_addr),
    .ld_data     (ld_data),
    .mem_wr_en   (mem_wr_en),
    .mem_wr_addr (mem_wr_addr),
    .mem_wr_data (mem_wr_data),
    .mem_rd_en   (mem_rd_en),
    .mem_rd_addr (mem_rd_addr),
    .mem_rd_data (mem_rd_data),
    .bias_valid  (bias_valid),
    .bias_ready  (bias_ready),
    .bias_data   (bias_data),
    .bias_idx    (bias_idx),
    .bias_last   (bias_last)
`ifdef STAGE_BIAS_CTRL_STALL_CNT_EN
    ,
    .stall_cnt   (stall_cnt)
`endif
  );

  // Bias memory: synchronous write, one-cycle read latency.
  always @(posedge clk) begin
    if (mem_wr_en) mem[mem_wr_addr] <= mem_wr_data;
    if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Stream scoreboard, read-credit and done-timing checks.
  always @(negedge clk) begin
    if (mon_en) begin
      if (mem_rd_en) begin
        chk("rd_outstanding", 64'((n_issued - n_accepted) < 2), 64'(1));
        chk("rd_addr", 64'(mem_rd_addr), 64'(n_issued));
        n_issued++;
      end
      if (last_acc_prev) chk("done_after_last", 64'(done), 64'(1));
      last_acc_prev = 1'b0;
      if (prev_stall) begin
        chk("valid_hold", 64'(bias_valid), 64'(1));
        chk("data_hold", 64'({bias_data, bias_idx, bias_last}), 64'({prev_data, prev_idx, prev_last}));
      end
      if (bias_valid && bias_ready) begin
        chk("word_expected", 64'(exp_q.size() > 0), 64'(1));
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          chk("bias_data", 64'(bias_data), 64'(mon_e.data));
          chk("bias_idx", 64'(bias_idx), 64'(mon_e.idx));
          chk("bias_last", 64'(bias_last), 64'(mon_e.last));
        end
        n_accepted++;
        last_acc_prev = bias_last;
      end
      prev_stall = bias_valid && !bias_ready;
      prev_data  = bias_data;
      prev_idx   = bias_idx;
      prev_last  = bias_last;
    end
    if (done) done_cnt++;
  end

  function automatic logic rdy(input int mode, input int k);
    case (mode)
      0:       return 1'b1;
      1:       return (k % 3) == 2;
      2:       return 1'($urandom_range(0, 1));
      default: return k >= 7;
    endcase
  endfunction

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ctrl"}, 64'({busy, done, ld_ready, mem_wr_en, mem_rd_en, bias_valid, bias_last}), 64'(7'b0010000));
    chk({tag, "_addr"}, 64'({mem_wr_addr, mem_rd_addr, bias_idx}), 64'(0));
    chk({tag, "_wdata"}, 64'(mem_wr_data), 64'(0));
    chk({tag, "_bdata"}, 64'(bias_data), 64'(0));
  endtask

  task automatic write_mem(input logic [AW-1:0] a, input logic [W-1:0] d);
    @(posedge clk); #1;
    ld_valid = 1'b1; ld_addr = a; ld_data = d;
    @(negedge clk);
    chk("wr_ready", 64'(ld_ready), 64'(1));
    chk("wr_pass", 64'({mem_wr_en, mem_wr_addr, mem_wr_data}), 64'({1'b1, a, d}));
    @(posedge clk); #1;
    ld_valid = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic do_pass(input logic [AW:0] cl, input int mode, input bit with_ld,
                         input logic [AW-1:0] la, input logic [W-1:0] ldat);
    int len;
    int fv;
    int dcyc;
    int d0;
    bias_word_t e;
    len = (int'(cl) > int'(DEPTH)) ? int'(DEPTH) : int'(cl);
    exp_q.delete();
    for (int i = 0; i < len; i++) begin
      e.data = ref_mem[i];
      e.idx  = AW'(i);
      e.last = (i == len - 1);
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    cfg_len = cl; start = 1'b1; bias_ready = rdy(mode, 0);
    if (with_ld) begin ld_valid = 1'b1; ld_addr = la; ld_data = ldat; end
    n_issued = 0; n_accepted = 0; prev_stall = 1'b0; last_acc_prev = 1'b0;
    d0 = done_cnt; mon_en = 1'b1;
    @(negedge clk);
    chk("ld_ready_at_start", 64'({ld_ready, mem_wr_en}), 64'(0));
    @(posedge clk); #1;
    start = 1'b0; cfg_len = (AW+1)'($urandom);
    fv = -1; dcyc = -1;
    for (int cyc = 0; cyc < 200 && dcyc < 0; cyc++) begin
      bias_ready = rdy(mode, cyc + 1);
      if (mode == 2) begin
        start = ($urandom_range(0, 3) == 0);
        cfg_len = (AW+1)'($urandom);
      end
      @(negedge clk);
      chk("ld_blocked_busy", 64'({ld_ready, mem_wr_en}), 64'(0));
      if (bias_valid && fv < 0) fv = cyc;
`ifdef STAGE_BIAS_CTRL_STALL_CNT_EN
      if (cyc == 0) chk("stall_clr", 64'(stall_cnt), 64'(0));
      if (mode == 3 && cyc == 6) chk("stall_5", 64'(stall_cnt), 64'(5));
`endif
      if (done) dcyc = cyc;
      else begin @(posedge clk); #1; end
    end
    chk("done_seen", 64'(dcyc >= 0), 64'(1));
    if (mode == 0) begin
      chk("first_valid_cyc", 64'(fv), 64'(len > 0 ? 1 : -1));
      chk("done_cyc", 64'(dcyc), 64'(len > 0 ? len + 1 : 0));
    end
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("idle_after", 64'({busy, done, ld_ready}), 64'(3'b001));
    chk("words_left", 64'(exp_q.size()), 64'(0));
    chk("one_done", 64'(done_cnt - d0), 64'(1));
    if (with_ld) begin
      chk("held_write_lands", 64'({mem_wr_en, mem_wr_addr, mem_wr_data}), 64'({1'b1, la, ldat}));
      @(posedge clk); #1;
      ld_valid = 1'b0;
      ref_mem[la] = ldat;
    end else begin
      chk("no_write", 64'(mem_wr_en), 64'(0));
    end
    mon_en = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int d0;
    bit hit;
    reset = 1'b1; start = 1'b0; cfg_len = '0; ld_valid = 1'b0;
    ld_addr = '0; ld_data = '0; bias_ready = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_vals("por");
    @(posedge clk); #1;
    reset = 1'b0;

    for (int i = 0; i < int'(DEPTH); i++) write_mem(AW'(i), W'(32'h100 + i));

    do_pass(4'd8, 0, 1'b0, '0, '0);
    do_pass(4'd3, 1, 1'b0, '0, '0);
    do_pass(4'd8, 0, 1'b1, 3'd5, 32'hDEAD_BEEF);
    do_pass(4'd8, 1, 1'b0, '0, '0);
    do_pass(4'd0, 0, 1'b0, '0, '0);
    do_pass(4'd12, 0, 1'b0, '0, '0);
    do_pass(4'd1, 0, 1'b0, '0, '0);

    // Reset in the middle of a pass, while idx 4 is presented.
    exp_q.delete();
    for (int i = 0; i < int'(DEPTH); i++) begin
      mon_e.data = ref_mem[i]; mon_e.idx = AW'(i); mon_e.last = (i == int'(DEPTH) - 1);
      exp_q.push_back(mon_e);
    end
    @(posedge clk); #1;
    cfg_len = 4'd8; start = 1'b1; bias_ready = 1'b1;
    n_issued = 0; n_accepted = 0; prev_stall = 1'b0; last_acc_prev = 1'b0; mon_en = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    hit = 1'b0;
    for (int k = 0; k < 20 && !hit; k++) begin
      @(negedge clk);
      if (bias_valid && bias_idx == 3'd4) hit = 1'b1;
    end
    chk("reached_idx4", 64'(hit), 64'(1));
    reset = 1'b1;
    d0 = done_cnt;
    @(posedge clk); #1;
    reset = 1'b0; mon_en = 1'b0; exp_q.delete();
    @(negedge clk);
    chk_reset_vals("midrst");
    repeat (4) @(posedge clk);
    #1;
    chk("no_done_after_reset", 64'(done_cnt - d0), 64'(0));

`ifdef STAGE_BIAS_CTRL_STALL_CNT_EN
    do_pass(4'd3, 3, 1'b0, '0, '0);
    do_pass(4'd2, 0, 1'b0, '0, '0);
`endif

    for (int r = 0; r < 20; r++) begin
      for (int w = 0; w < int'($urandom_range(1, 3)); w++) write_mem(AW'($urandom), $urandom);
      do_pass((AW+1)'($urandom_range(0, 15)), (r % 3 == 0) ? 1 : 2, 1'b0, '0, '0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
